// File: rtl/xor_secuenciador_paridad_if.sv
// Requester/XOR-unit bundle for the parity sequencer.
// master: requesters plus external XOR; slave: the controller.
interface xor_secuenciador_paridad_if #(
  parameter int ANCHO = 8
);
  logic [1:0]       Solicitud;
  logic [ANCHO-1:0] Dato0;
  logic [ANCHO-1:0] Dato1;
  logic [1:0]       Concedido;
  logic [1:0]       Listo;
  logic             Paridad;
  logic             Ocupado;
  logic             Error;
  logic [1:0]       XorEntrada;
  logic             XorSalida;

  modport master (
    output Solicitud, Dato0, Dato1, XorSalida,
    input  Concedido, Listo, Paridad, Ocupado,
    input  Error, XorEntrada
  );

  modport slave (
    input  Solicitud, Dato0, Dato1, XorSalida,
    output Concedido, Listo, Paridad, Ocupado,
    output Error, XorEntrada
  );
endinterface

// File: rtl/xor_secuenciador_paridad.sv
// Bit-serial parity through one shared XOR, two requesters.
// Optional self-check enabled by macro XOR_SEC_VERIFICA_EN.
module xor_secuenciador_paridad #(
  parameter int ANCHO = 8
) (
  input logic                       Reloj,
  input logic                       Reset_n,
  xor_secuenciador_paridad_if.slave bus
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam logic [CW-1:0] ULT = CW'(ANCHO - 1);

  typedef enum logic [1:0] {
    REPOSO,
    CALCULA,
    ENTREGA
  } estado_t;

  estado_t          estado;
  logic             puntero;
  logic             dueno;
  logic             elige;
  logic [ANCHO-1:0] sr;
  logic             acc;
  logic [CW-1:0]    cuenta;
  logic [1:0]       concedido;
  logic [1:0]       listo;
  logic             paridad;
  logic             ocupado;
  logic             ultimo;

  assign ultimo = (estado == CALCULA) && (cuenta == ULT);

  assign bus.Concedido  = concedido;
  assign bus.Listo      = listo;
  assign bus.Paridad    = paridad;
  assign bus.Ocupado    = ocupado;
  assign bus.XorEntrada = (estado == CALCULA) ?
                          {acc, sr[0]} : 2'b00;

  // Arbitration: lone requester wins, otherwise pointer decides
  always_comb begin
    elige = 1'b0;
    unique case (1'b1)
      (bus.Solicitud == 2'b11): elige = puntero;
      (bus.Solicitud == 2'b10): elige = 1'b1;
      default:                  elige = 1'b0;
    endcase
  end

  // Main FSM: grant, shift through shared XOR, deliver result
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      estado    <= REPOSO;
      puntero   <= 1'b0;
      dueno     <= 1'b0;
      sr        <= '0;
      acc       <= 1'b0;
      cuenta    <= '0;
      concedido <= 2'b00;
      listo     <= 2'b00;
      paridad   <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      unique case (estado)
        REPOSO: begin
          if (|bus.Solicitud) begin
            sr        <= elige ? bus.Dato1 : bus.Dato0;
            acc       <= 1'b0;
            cuenta    <= '0;
            dueno     <= elige;
            concedido <= elige ? 2'b10 : 2'b01;
            ocupado   <= 1'b1;
            estado    <= CALCULA;
          end
        end
        CALCULA: begin
          concedido <= 2'b00;
          acc       <= bus.XorSalida;
          sr        <= sr >> 1;
          cuenta    <= cuenta + CW'(1);
          if (cuenta == ULT) begin
            paridad <= bus.XorSalida;
            listo   <= dueno ? 2'b10 : 2'b01;
            estado  <= ENTREGA;
          end
        end
        ENTREGA: begin
          listo   <= 2'b00;
          puntero <= ~dueno;
          ocupado <= 1'b0;
          estado  <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

`ifdef XOR_SEC_VERIFICA_EN
  logic chk;
  logic err;

  // Reference parity at grant, compared with the serial result
  always_ff @(posedge Reloj or negedge Reset_n) begin
    if (!Reset_n) begin
      chk <= 1'b0;
      err <= 1'b0;
    end else begin
      if (estado == REPOSO && |bus.Solicitud)
        chk <= elige ? ^bus.Dato1 : ^bus.Dato0;
      err <= ultimo ? (bus.XorSalida != chk) : 1'b0;
    end
  end

  assign bus.Error = err;
`else
  assign bus.Error = 1'b0;
`endif

endmodule

// File: tb/tb_xor_secuenciador_paridad.sv
// Bench for xor_secuenciador_paridad: table jobs,
// alternation, mid-job reset and a faulty XOR unit.
module tb_xor_secuenciador_paridad;

  localparam int ANCHO = 8;

  logic Reloj = 1'b0;
  logic Reset_n = 1'b0;
  logic faulty = 1'b0;

  always #5 Reloj = ~Reloj;

  xor_secuenciador_paridad_if #(.ANCHO(ANCHO)) bus ();

  xor_secuenciador_paridad #(.ANCHO(ANCHO)) dut (
    .Reloj   (Reloj),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // External XOR; the faulty variant is an AND gate
  assign bus.XorSalida = faulty ?
    (bus.XorEntrada[1] & bus.XorEntrada[0]) :
    (bus.XorEntrada[1] ^ bus.XorEntrada[0]);

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  typedef struct packed {
    logic [1:0] lst;
    logic       par;
    logic       err;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  logic [ANCHO-1:0] mon_d;
  logic             prev_listo = 1'b0;

  // Scoreboard: push at grant, pop and compare at Listo
  always @(negedge Reloj) begin
    if (!Reset_n) begin
      sb.delete();
      prev_listo = 1'b0;
    end else begin
      if (bus.Concedido != 2'b00) begin
        mon_d = bus.Concedido[1] ? bus.Dato1 : bus.Dato0;
        e.lst = bus.Concedido;
        e.par = faulty ? 1'b0 : ^mon_d;
`ifdef XOR_SEC_VERIFICA_EN
        e.err = (e.par != ^mon_d);
`else
        e.err = 1'b0;
`endif
        sb.push_back(e);
      end
      if (bus.Listo != 2'b00) begin
        chk("listo_pulse", prev_listo, 0);
        if (sb.size() == 0) begin
          chk("listo_unexpected", bus.Listo, 0);
        end else begin
          e = sb.pop_front();
          chk("listo_owner", bus.Listo, e.lst);
          chk("paridad", bus.Paridad, e.par);
          chk("error", bus.Error, e.err);
        end
      end else if (bus.Error) begin
        chk("error_stray", bus.Error, 0);
      end
      prev_listo = |bus.Listo;
    end
  end

  task automatic wait_grant();
    int c = 0;
    do begin
      @(negedge Reloj);
      c++;
    end while (bus.Concedido == 2'b00 && c < 30);
    chk("grant_seen", |bus.Concedido, 1);
  endtask

  task automatic wait_listo(output int lat);
    lat = 0;
    do begin
      @(negedge Reloj);
      lat++;
    end while (bus.Listo == 2'b00 && lat < 30);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge Reloj);
      if (!bus.Ocupado && sb.size() == 0) break;
    end
    chk("idle", {bus.Ocupado, sb.size() == 0}, 2'b01);
  endtask

  typedef struct {
    logic [1:0]       sol;
    logic [ANCHO-1:0] d0;
    logic [ANCHO-1:0] d1;
    logic [1:0]       conc;
    logic             par;
  } vec_t;

  vec_t tab[7];

  initial begin
    int lat;
    int last_g;
    int k;
    int low_run;
    bit seen_high;
    int nl;

    tab[0] = '{2'b01, 8'hA5, 8'h00, 2'b01, 1'b0};
    tab[1] = '{2'b01, 8'h07, 8'h00, 2'b01, 1'b1};
    tab[2] = '{2'b10, 8'h00, 8'hFF, 2'b10, 1'b0};
    tab[3] = '{2'b11, 8'h01, 8'h03, 2'b01, 1'b1};
    tab[4] = '{2'b11, 8'h00, 8'h80, 2'b10, 1'b1};
    tab[5] = '{2'b10, 8'h00, 8'h7F, 2'b10, 1'b1};
    tab[6] = '{2'b11, 8'hFE, 8'h00, 2'b01, 1'b1};

    bus.Solicitud = 2'b11;
    bus.Dato0 = 8'h01;
    bus.Dato1 = 8'h03;
    Reset_n = 1'b0;
    repeat (2) @(negedge Reloj);
    chk("reset_outs",
        {bus.Concedido, bus.Listo, bus.Paridad,
         bus.Ocupado, bus.Error, bus.XorEntrada}, 0);
    Reset_n = 1'b1;

    // Both holding: alternate 0,1,0,1 every ANCHO+2 cycles
    k = 0;
    last_g = 0;
    low_run = 0;
    seen_high = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Reloj);
      if (i == 1) chk("first_grant", bus.Concedido, 2'b01);
      if (bus.Concedido != 2'b00) begin
        chk("alt_grant", bus.Concedido,
            (k % 2 == 0) ? 2'b01 : 2'b10);
        if (k > 0) chk("grant_spacing", i - last_g, ANCHO + 2);
        last_g = i;
        k++;
      end
      if (!bus.Ocupado) begin
        low_run++;
      end else begin
        if (seen_high && low_run != 0)
          chk("ocupado_gap", low_run, 1);
        low_run = 0;
        seen_high = 1;
      end
    end
    bus.Solicitud = 2'b00;
    chk("alt_count", k, 4);
    wait_idle();

    for (int t = 0; t < 7; t++) begin
      bus.Solicitud = tab[t].sol;
      bus.Dato0 = tab[t].d0;
      bus.Dato1 = tab[t].d1;
      wait_grant();
      chk("tab_grant", bus.Concedido, tab[t].conc);
      bus.Solicitud = 2'b00;
      wait_listo(lat);
      chk("tab_latency", lat, ANCHO);
      chk("tab_paridad", bus.Paridad, tab[t].par);
      wait_idle();
    end

    // Reset in the middle of a job discards it
    bus.Solicitud = 2'b10;
    bus.Dato1 = 8'h3C;
    wait_grant();
    chk("mr_grant", bus.Concedido, 2'b10);
    repeat (3) @(negedge Reloj);
    #2 Reset_n = 1'b0;
    #1;
    chk("mr_ocupado", bus.Ocupado, 0);
    chk("mr_outs",
        {bus.Concedido, bus.Listo, bus.XorEntrada}, 0);
    nl = 0;
    repeat (2) begin
      @(negedge Reloj);
      if (bus.Listo != 2'b00) nl++;
    end
    Reset_n = 1'b1;
    wait_grant();
    chk("mr_no_listo", nl, 0);
    chk("mr_regrant", bus.Concedido, 2'b10);
    bus.Solicitud = 2'b00;
    wait_listo(lat);
    chk("mr_latency", lat, ANCHO);
    wait_idle();

    // Broken XOR unit: checker flags it when present
    faulty = 1'b1;
    bus.Solicitud = 2'b01;
    bus.Dato0 = 8'h01;
    wait_grant();
    bus.Solicitud = 2'b00;
    wait_listo(lat);
    chk("fault_listo", bus.Listo, 2'b01);
    chk("fault_paridad", bus.Paridad, 0);
`ifdef XOR_SEC_VERIFICA_EN
    chk("fault_error", bus.Error, 1);
`else
    chk("fault_error", bus.Error, 0);
`endif
    wait_idle();
    faulty = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
